// File: rtl/segment_text_scroller.sv
// Message buffer and scroll sequencer feeding two per-digit ASCII decoders.
// Loads ASCII bytes while idle, then steps a two-character window through message+blank.
module segment_text_scroller #(
  parameter int unsigned CLKS_PER_STEP = 12_500_000,
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  BLANK         = 8'h20
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Char_DV,
  input  logic [7:0] i_Char,
  input  logic       i_Start,
  input  logic       i_Clear,
  output logic       o_Load_Ready,
  output logic       o_Scrolling,
  output logic [7:0] o_Char_Left,
  output logic [7:0] o_Char_Right,
  output logic       o_Wrap
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);
  localparam int unsigned IdxW = $clog2(MAX_LEN);
  localparam int unsigned CntW = $clog2(CLKS_PER_STEP);
  localparam logic [LenW-1:0] LenMax  = LenW'(MAX_LEN);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_STEP - 1);

  typedef enum logic [0:0] {StIdle, StScroll} state_e;

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] pos_q, pos_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap_pend_q, wrap_pend_d;
  logic            wrap_q;
  logic [7:0]      char_left_q, char_right_q;
  logic [7:0]      msg_q [MAX_LEN];
  logic            wr_en;

  logic [LenW-1:0] right_idx;
  logic [7:0]      win_left, win_right;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      pos_q        <= '0;
      cnt_q        <= '0;
      wrap_pend_q  <= 1'b0;
      wrap_q       <= 1'b0;
      char_left_q  <= BLANK;
      char_right_q <= BLANK;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      wrap_pend_q  <= wrap_pend_d;
      // Delayed one cycle so the pulse lines up with the registered window.
      wrap_q       <= wrap_pend_q;
      char_left_q  <= win_left;
      char_right_q <= win_right;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge i_Clk) begin
    if (wr_en) begin
      msg_q[len_q[IdxW-1:0]] <= i_Char;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pos_d       = pos_q;
    cnt_d       = cnt_q;
    wrap_pend_d = 1'b0;
    wr_en       = 1'b0;
    if (i_Clear) begin
      state_d = StIdle;
      len_d   = '0;
      pos_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_Start && (len_q != '0)) begin
            state_d = StScroll;
            pos_d   = '0;
            cnt_d   = '0;
          end else if (i_Char_DV && (len_q < LenMax)) begin
            wr_en = 1'b1;
            len_d = len_q + LenW'(1);
          end
        end
        StScroll: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (pos_q == len_q) begin
              pos_d       = '0;
              wrap_pend_d = 1'b1;
            end else begin
              pos_d = pos_q + LenW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Window over the virtual sequence: buffer followed by one blank slot at index len.
  always_comb begin
    right_idx    = (pos_q == len_q) ? '0 : pos_q + LenW'(1);
    win_left     = BLANK;
    win_right    = BLANK;
    o_Scrolling  = (state_q == StScroll);
    o_Load_Ready = (state_q == StIdle) && (len_q < LenMax);
    if (state_q == StScroll) begin
      if (pos_q < len_q) begin
        win_left = msg_q[pos_q[IdxW-1:0]];
      end
      if (right_idx < len_q) begin
        win_right = msg_q[right_idx[IdxW-1:0]];
      end
    end
  end

  assign o_Char_Left  = char_left_q;
  assign o_Char_Right = char_right_q;
  assign o_Wrap       = wrap_q;

endmodule

// File: tb/tb_segment_text_scroller.sv
// Self-checking bench for segment_text_scroller: directed plan steps plus random traffic,
// checked every cycle against a time-based reference model.
module tb_segment_text_scroller;

  localparam int unsigned C   = 4;
  localparam int unsigned MAX = 4;
  localparam logic [7:0]  BL  = 8'h20;

  logic       clk = 1'b0;
  logic       rst, dv, start, clr;
  logic [7:0] ch;
  logic       load_ready, scrolling, wrap;
  logic [7:0] left, right;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: message, length, scrolling flag, edges elapsed since start.
  logic [7:0] m_msg [MAX];
  int         m_len    = 0;
  bit         m_scroll = 1'b0;
  int         m_t      = 0;
  logic [7:0] e_left   = BL;
  logic [7:0] e_right  = BL;
  bit         e_wrap   = 1'b0;

  segment_text_scroller #(
    .CLKS_PER_STEP(C),
    .MAX_LEN      (MAX),
    .BLANK        (BL)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Char_DV   (dv),
    .i_Char      (ch),
    .i_Start     (start),
    .i_Clear     (clr),
    .o_Load_Ready(load_ready),
    .o_Scrolling (scrolling),
    .o_Char_Left (left),
    .o_Char_Right(right),
    .o_Wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seq_at(int i);
    return (i < m_len) ? m_msg[i] : BL;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic cyc(input bit i_dv, input logic [7:0] i_ch, input bit i_st,
                     input bit i_cl, input bit i_rs);
    int p, pos;
    logic [7:0] wl, wr;
    bit ww;
    dv = i_dv; ch = i_ch; start = i_st; clr = i_cl; rst = i_rs;
    @(posedge clk);
    wl = BL; wr = BL; ww = 1'b0;
    if (m_scroll) begin
      p   = m_len + 1;
      pos = (m_t / C) % p;
      wl  = seq_at(pos);
      wr  = seq_at((pos + 1) % p);
      ww  = (m_t > 0) && (m_t % (C * p) == 0);
    end
    if (i_rs) begin
      m_scroll = 1'b0; m_len = 0; m_t = 0;
      e_left = BL; e_right = BL; e_wrap = 1'b0;
    end else begin
      e_left = wl; e_right = wr; e_wrap = ww;
      if (i_cl) begin
        m_scroll = 1'b0; m_len = 0; m_t = 0;
      end else if (m_scroll) begin
        m_t++;
      end else if (i_st && m_len > 0) begin
        m_scroll = 1'b1; m_t = 0;
      end else if (i_dv && m_len < MAX) begin
        m_msg[m_len] = i_ch;
        m_len++;
      end
    end
    #1;
    check("left", left, e_left);
    check("right", right, e_right);
    check("wrap", {7'd0, wrap}, {7'd0, e_wrap});
    check("scrolling", {7'd0, scrolling}, {7'd0, m_scroll});
    check("load_ready", {7'd0, load_ready}, {7'd0, (!m_scroll && m_len < MAX)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] c);
    cyc(1'b1, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    dv = 1'b0; ch = 8'h00; start = 1'b0; clr = 1'b0; rst = 1'b1;

    // Reset state, with literal expectations as well as the model.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("reset_left", left, 8'h20);
    check("reset_right", right, 8'h20);
    check("reset_ready", {7'd0, load_ready}, 8'd1);
    check("reset_scroll", {7'd0, scrolling}, 8'd0);
    check("reset_wrap", {7'd0, wrap}, 8'd0);
    idle(2);

    // Load and scroll "AB" through more than one full pass.
    load(8'h41); load(8'h42); go();
    idle(1);
    check("ab_first_left", left, 8'h41);
    check("ab_first_right", right, 8'h42);
    idle(30);

    // Overflow: fifth byte dropped, period 5 ending in blank.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(2);
    load(8'h31); load(8'h32); load(8'h33); load(8'h34); load(8'h35);
    check("ovf_ready_low", {7'd0, load_ready}, 8'd0);
    go();
    idle(44);

    // Start guards: empty start ignored; start wins over same-cycle append.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
    go();
    check("empty_start", {7'd0, scrolling}, 8'd0);
    load(8'h58);
    cyc(1'b1, 8'h59, 1'b1, 1'b0, 1'b0);
    idle(20);

    // Clear during the third step, then reload "C".
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
    load(8'h41); load(8'h42); go();
    idle(9);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("clr_left", left, 8'h20);
    check("clr_ready", {7'd0, load_ready}, 8'd1);
    load(8'h43); go();
    idle(1);
    check("c_left", left, 8'h43);
    check("c_right", right, 8'h20);
    idle(10);

    // Reset mid-scroll, then single character "Z".
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    load(8'h41); load(8'h42); go();
    idle(6);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    load(8'h5a); go();
    idle(26);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 40), 8'($urandom_range(8'h21, 8'h7e)),
          ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 2),
          ($urandom_range(0, 999) < 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
